// File: rtl/execute.sv
// Execute stage of the ECAP5-DPROC pipeline (RV32I, XLEN=32).
// Accepts one decoded instruction per valid/ready handshake, computes the ALU
// result and the branch decision/target, and registers everything toward the
// load-store stage with a single pipeline register (latency 1).
// Optional feature macro: EXECUTE_MISALIGN_CHECK_EN -- when defined, a taken
// branch whose target is not word aligned raises misaligned_o instead of
// branch_o and drops the instruction's register write.
module execute (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        input_ready_o,
  input  logic        input_valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] alu_operand1_i,
  input  logic [31:0] alu_operand2_i,
  input  logic [2:0]  alu_op_i,
  input  logic        alu_sub_i,
  input  logic        alu_shift_left_i,
  input  logic        alu_signed_shift_i,
  input  logic [2:0]  branch_cond_i,
  input  logic [19:0] branch_offset_i,
  input  logic        reg_write_i,
  input  logic [4:0]  reg_addr_i,
  input  logic        ls_enable_i,
  input  logic        ls_write_i,
  input  logic [31:0] ls_write_data_i,
  input  logic [3:0]  ls_sel_i,
  input  logic        ls_unsigned_load_i,
  input  logic        output_ready_i,
  output logic        output_valid_o,
  output logic [31:0] result_o,
  output logic        reg_write_o,
  output logic [4:0]  reg_addr_o,
  output logic        ls_enable_o,
  output logic        ls_write_o,
  output logic [31:0] ls_write_data_o,
  output logic [3:0]  ls_sel_o,
  output logic        ls_unsigned_load_o,
  output logic        branch_o,
  output logic [31:0] branch_target_o,
  output logic        misaligned_o
);

  typedef enum logic [2:0] {
    COND_NONE = 3'b000,
    COND_EQ   = 3'b001,
    COND_NE   = 3'b010,
    COND_LT   = 3'b011,
    COND_GE   = 3'b100,
    COND_LTU  = 3'b101,
    COND_GEU  = 3'b110,
    COND_ALL  = 3'b111
  } cond_e;

  // Fields that travel untouched (apart from the misalign write kill) to load-store.
  typedef struct packed {
    logic        reg_write;
    logic [4:0]  reg_addr;
    logic        ls_enable;
    logic        ls_write;
    logic [31:0] ls_write_data;
    logic [3:0]  ls_sel;
    logic        ls_unsigned_load;
  } pass_t;

  logic        output_valid_q, output_valid_d;
  logic        branch_q, branch_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] result_q;
  logic [31:0] branch_target_q;
  pass_t       pass_q, pass_d;

  logic        accept;
  logic [4:0]  shamt;
  logic [31:0] alu_result;
  logic        taken;
  logic [31:0] target;
  logic        target_misaligned;

  // The stage frees up when empty or when its current output drains this cycle.
  assign input_ready_o = !output_valid_q || output_ready_i;
  assign accept        = input_valid_i && input_ready_o;
  assign shamt         = alu_operand2_i[4:0];

  // ALU: the result is a pure function of the current decode inputs.
  always_comb begin
    // NOTE: assign a default before the case so every path drives alu_result
    // and no latch is inferred.
    alu_result = 32'd0;
    unique case (alu_op_i)
      3'b000: alu_result = alu_sub_i ? alu_operand1_i - alu_operand2_i
                                     : alu_operand1_i + alu_operand2_i;
      3'b001, 3'b101: begin
        if (alu_shift_left_i)        alu_result = alu_operand1_i << shamt;
        else if (alu_signed_shift_i) alu_result = $signed(alu_operand1_i) >>> shamt;
        else                         alu_result = alu_operand1_i >> shamt;
      end
      3'b010: alu_result = {31'd0, $signed(alu_operand1_i) < $signed(alu_operand2_i)};
      3'b011: alu_result = {31'd0, alu_operand1_i < alu_operand2_i};
      3'b100: alu_result = alu_operand1_i ^ alu_operand2_i;
      3'b110: alu_result = alu_operand1_i | alu_operand2_i;
      3'b111: alu_result = alu_operand1_i & alu_operand2_i;
      default: alu_result = 32'd0;
    endcase
  end

  // Branch decision from the operand comparison selected by the condition code.
  always_comb begin
    taken = 1'b0;
    unique case (cond_e'(branch_cond_i))
      COND_NONE: taken = 1'b0;
      COND_EQ:   taken = alu_operand1_i == alu_operand2_i;
      COND_NE:   taken = alu_operand1_i != alu_operand2_i;
      COND_LT:   taken = $signed(alu_operand1_i) < $signed(alu_operand2_i);
      COND_GE:   taken = $signed(alu_operand1_i) >= $signed(alu_operand2_i);
      COND_LTU:  taken = alu_operand1_i < alu_operand2_i;
      COND_GEU:  taken = alu_operand1_i >= alu_operand2_i;
      COND_ALL:  taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

  // Offset is in halfwords; sign-extend the 21-bit byte offset and wrap mod 2^32.
  assign target = pc_i + {{11{branch_offset_i[19]}}, branch_offset_i, 1'b0};

`ifdef EXECUTE_MISALIGN_CHECK_EN
  assign target_misaligned = target[1:0] != 2'b00;
`else
  assign target_misaligned = 1'b0;
`endif

  // Next-state for the handshake and the single-cycle redirect pulses.
  always_comb begin
    output_valid_d = output_valid_q;
    if (accept)              output_valid_d = 1'b1;
    else if (output_ready_i) output_valid_d = 1'b0;
    // Pulses only follow an accept, so a stall never repeats them.
    branch_d     = accept && taken && !target_misaligned;
    misaligned_d = accept && taken && target_misaligned;
    pass_d = '{reg_write:        reg_write_i && !(taken && target_misaligned),
               reg_addr:         reg_addr_i,
               ls_enable:        ls_enable_i,
               ls_write:         ls_write_i,
               ls_write_data:    ls_write_data_i,
               ls_sel:           ls_sel_i,
               ls_unsigned_load: ls_unsigned_load_i};
  end

  // Pipeline register: data loads only on accept, target only on a taken branch.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      output_valid_q  <= 1'b0;
      branch_q        <= 1'b0;
      misaligned_q    <= 1'b0;
      result_q        <= 32'd0;
      branch_target_q <= 32'd0;
      pass_q          <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      output_valid_q <= output_valid_d;
      branch_q       <= branch_d;
      misaligned_q   <= misaligned_d;
      if (accept) begin
        result_q <= alu_result;
        pass_q   <= pass_d;
        if (taken) branch_target_q <= target;
      end
    end
  end

  assign output_valid_o     = output_valid_q;
  assign result_o           = result_q;
  assign reg_write_o        = pass_q.reg_write;
  assign reg_addr_o         = pass_q.reg_addr;
  assign ls_enable_o        = pass_q.ls_enable;
  assign ls_write_o         = pass_q.ls_write;
  assign ls_write_data_o    = pass_q.ls_write_data;
  assign ls_sel_o           = pass_q.ls_sel;
  assign ls_unsigned_load_o = pass_q.ls_unsigned_load;
  assign branch_o           = branch_q;
  assign branch_target_o    = branch_target_q;
  assign misaligned_o       = misaligned_q;

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for the execute stage: directed vectors push expected
// responses into a scoreboard; a monitor pops and compares on each output
// handshake and checks stall stability and single-cycle redirect pulses.
module tb_execute;

  logic        clk;
  logic        rst_i;
  logic        input_ready_o;
  logic        input_valid_i;
  logic [31:0] pc_i, alu_operand1_i, alu_operand2_i;
  logic [2:0]  alu_op_i;
  logic        alu_sub_i, alu_shift_left_i, alu_signed_shift_i;
  logic [2:0]  branch_cond_i;
  logic [19:0] branch_offset_i;
  logic        reg_write_i;
  logic [4:0]  reg_addr_i;
  logic        ls_enable_i, ls_write_i, ls_unsigned_load_i;
  logic [31:0] ls_write_data_i;
  logic [3:0]  ls_sel_i;
  logic        output_ready_i;
  logic        output_valid_o;
  logic [31:0] result_o;
  logic        reg_write_o;
  logic [4:0]  reg_addr_o;
  logic        ls_enable_o, ls_write_o, ls_unsigned_load_o;
  logic [31:0] ls_write_data_o;
  logic [3:0]  ls_sel_o;
  logic        branch_o;
  logic [31:0] branch_target_o;
  logic        misaligned_o;

  execute dut (
    .clk_i(clk), .rst_i(rst_i),
    .input_ready_o(input_ready_o), .input_valid_i(input_valid_i),
    .pc_i(pc_i), .alu_operand1_i(alu_operand1_i), .alu_operand2_i(alu_operand2_i),
    .alu_op_i(alu_op_i), .alu_sub_i(alu_sub_i), .alu_shift_left_i(alu_shift_left_i),
    .alu_signed_shift_i(alu_signed_shift_i), .branch_cond_i(branch_cond_i),
    .branch_offset_i(branch_offset_i), .reg_write_i(reg_write_i), .reg_addr_i(reg_addr_i),
    .ls_enable_i(ls_enable_i), .ls_write_i(ls_write_i), .ls_write_data_i(ls_write_data_i),
    .ls_sel_i(ls_sel_i), .ls_unsigned_load_i(ls_unsigned_load_i),
    .output_ready_i(output_ready_i), .output_valid_o(output_valid_o), .result_o(result_o),
    .reg_write_o(reg_write_o), .reg_addr_o(reg_addr_o), .ls_enable_o(ls_enable_o),
    .ls_write_o(ls_write_o), .ls_write_data_o(ls_write_data_o), .ls_sel_o(ls_sel_o),
    .ls_unsigned_load_o(ls_unsigned_load_o), .branch_o(branch_o),
    .branch_target_o(branch_target_o), .misaligned_o(misaligned_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        rw;
    logic [4:0]  ra;
    logic        lse, lsw, lsu;
    logic [31:0] lswd;
    logic [3:0]  sel;
    logic        br, mis;
    logic [31:0] tgt;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          n_out = 0;
  logic [31:0] seq = 32'd0;
  bit          fresh = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the head of the scoreboard while an output is presented.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_i) begin
      fresh = 1'b1;
    end else if (output_valid_o) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {31'd0, output_valid_o}, 32'd0);
      end else begin
        e = sb[0];
        check("result", result_o, e.res);
        check("reg_write", {31'd0, reg_write_o}, {31'd0, e.rw});
        check("reg_addr", {27'd0, reg_addr_o}, {27'd0, e.ra});
        check("ls_enable", {31'd0, ls_enable_o}, {31'd0, e.lse});
        check("ls_write", {31'd0, ls_write_o}, {31'd0, e.lsw});
        check("ls_write_data", ls_write_data_o, e.lswd);
        check("ls_sel", {28'd0, ls_sel_o}, {28'd0, e.sel});
        check("ls_unsigned", {31'd0, ls_unsigned_load_o}, {31'd0, e.lsu});
        if (fresh) begin
          check("branch", {31'd0, branch_o}, {31'd0, e.br});
          check("misaligned", {31'd0, misaligned_o}, {31'd0, e.mis});
          if (e.br || e.mis) check("branch_target", branch_target_o, e.tgt);
        end else begin
          check("branch_repeat", {31'd0, branch_o}, 32'd0);
          check("misaligned_repeat", {31'd0, misaligned_o}, 32'd0);
        end
        if (output_ready_i) begin
          void'(sb.pop_front());
          n_out++;
          fresh = 1'b1;
        end else begin
          fresh = 1'b0;
        end
      end
    end else begin
      fresh = 1'b1;
    end
  end

  // Issue one instruction and wait (bounded) for it to be accepted.
  task automatic send(input logic [31:0] pc, input logic [31:0] op1, input logic [31:0] op2,
                      input logic [2:0] op, input logic sub, input logic left, input logic sgn,
                      input logic [2:0] cond, input logic [19:0] off, input logic rw,
                      input logic [31:0] exp_res, input logic exp_taken, input logic [31:0] exp_tgt);
    exp_t e;
    bit   done;
    seq = seq + 32'd1;
    pc_i = pc; alu_operand1_i = op1; alu_operand2_i = op2; alu_op_i = op;
    alu_sub_i = sub; alu_shift_left_i = left; alu_signed_shift_i = sgn;
    branch_cond_i = cond; branch_offset_i = off;
    reg_write_i = rw; reg_addr_i = seq[4:0];
    ls_enable_i = seq[0]; ls_write_i = seq[1]; ls_unsigned_load_i = seq[2];
    ls_write_data_i = 32'hA500_0000 ^ seq; ls_sel_i = seq[3:0];
    e.res = exp_res; e.rw = rw; e.ra = seq[4:0];
    e.lse = seq[0]; e.lsw = seq[1]; e.lsu = seq[2];
    e.lswd = 32'hA500_0000 ^ seq; e.sel = seq[3:0];
    e.br = exp_taken; e.mis = 1'b0; e.tgt = exp_tgt;
`ifdef EXECUTE_MISALIGN_CHECK_EN
    if (exp_taken && exp_tgt[1:0] != 2'b00) begin
      e.br = 1'b0; e.mis = 1'b1; e.rw = 1'b0;
    end
`endif
    input_valid_i = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (input_ready_o) begin
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    input_valid_i = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: instruction %0d not accepted within 50 cycles", seq);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'd0, output_valid_o}, 32'd0);
    check({tag, "_branch"}, {31'd0, branch_o}, 32'd0);
    check({tag, "_misaligned"}, {31'd0, misaligned_o}, 32'd0);
    check({tag, "_result"}, result_o, 32'd0);
    check({tag, "_target"}, branch_target_o, 32'd0);
    check({tag, "_passthru"},
          {reg_write_o, reg_addr_o, ls_enable_o, ls_write_o, ls_sel_o, ls_unsigned_load_o, 19'd0},
          32'd0);
    check({tag, "_ls_wdata"}, ls_write_data_o, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    rst_i = 1'b0; input_valid_i = 1'b0; output_ready_i = 1'b1;
    pc_i = '0; alu_operand1_i = '0; alu_operand2_i = '0; alu_op_i = '0;
    alu_sub_i = 0; alu_shift_left_i = 0; alu_signed_shift_i = 0;
    branch_cond_i = '0; branch_offset_i = '0; reg_write_i = 0; reg_addr_i = '0;
    ls_enable_i = 0; ls_write_i = 0; ls_write_data_i = '0; ls_sel_i = '0; ls_unsigned_load_i = 0;
    idle(2);
    check_all_zero("reset");
    check("reset_ready", {31'd0, input_ready_o}, 32'd1);
    @(negedge clk); rst_i = 1'b1;
    idle(1);

    // ALU vectors: pc, op1, op2, op, sub, left, sgn, cond, off, rw, result, taken, target
    send(32'h0, 32'hFFFF_FFFF, 32'h1,        3'b000, 0, 0, 0, 3'b000, 20'h0, 1, 32'h0000_0000, 0, 32'h0);
    send(32'h0, 32'h5,         32'h7,        3'b000, 1, 0, 0, 3'b000, 20'h0, 1, 32'hFFFF_FFFE, 0, 32'h0);
    send(32'h0, 32'h8000_0000, 32'h4,        3'b101, 0, 0, 1, 3'b000, 20'h0, 1, 32'hF800_0000, 0, 32'h0);
    send(32'h0, 32'h8000_0000, 32'h4,        3'b101, 0, 0, 0, 3'b000, 20'h0, 0, 32'h0800_0000, 0, 32'h0);
    send(32'h0, 32'h1,         32'h23,       3'b001, 0, 1, 0, 3'b000, 20'h0, 1, 32'h0000_0008, 0, 32'h0);
    send(32'h0, 32'hFFFF_FFFF, 32'h1,        3'b010, 0, 0, 0, 3'b000, 20'h0, 1, 32'h0000_0001, 0, 32'h0);
    send(32'h0, 32'hFFFF_FFFF, 32'h1,        3'b011, 0, 0, 0, 3'b000, 20'h0, 1, 32'h0000_0000, 0, 32'h0);
    send(32'h0, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 0, 0, 0, 3'b000, 20'h0, 1, 32'h0FF0_0FF0, 0, 32'h0);
    send(32'h0, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b110, 0, 0, 0, 3'b000, 20'h0, 1, 32'hFFF0_FFF0, 0, 32'h0);
    send(32'h0, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b111, 0, 0, 0, 3'b000, 20'h0, 1, 32'hF000_F000, 0, 32'h0);

    // Branch vectors
    send(32'h100,       32'hFFFF_FFFF, 32'h1, 3'b000, 0, 0, 0, 3'b011, 20'hFFFF8, 0, 32'h0, 1, 32'h0000_00F0);
    send(32'h100,       32'hFFFF_FFFF, 32'h1, 3'b000, 0, 0, 0, 3'b101, 20'hFFFF8, 0, 32'h0, 0, 32'h0);
    send(32'h1000,      32'h7,         32'h7, 3'b000, 0, 0, 0, 3'b001, 20'h00010, 0, 32'hE, 1, 32'h0000_1020);
    send(32'h1000,      32'h7,         32'h7, 3'b000, 0, 0, 0, 3'b010, 20'h00010, 0, 32'hE, 0, 32'h0);
    send(32'h200,       32'hFFFF_FFFF, 32'h1, 3'b000, 0, 0, 0, 3'b100, 20'h00002, 0, 32'h0, 0, 32'h0);
    send(32'h200,       32'hFFFF_FFFF, 32'h1, 3'b000, 0, 0, 0, 3'b110, 20'h00002, 0, 32'h0, 1, 32'h0000_0204);
    send(32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'h4, 3'b000, 0, 0, 0, 3'b111, 20'h00010, 1, 32'hFFFF_FFF4, 1, 32'h0000_0010);
    send(32'h0,         32'h0,         32'h4, 3'b000, 0, 0, 0, 3'b111, 20'h00001, 1, 32'h0000_0004, 1, 32'h0000_0002);
    idle(2);

    // Stall: taken BLT held for 3 cycles; branch_o must pulse once.
    output_ready_i = 1'b0;
    send(32'h100, 32'hFFFF_FFFF, 32'h1, 3'b000, 0, 0, 0, 3'b011, 20'hFFFF8, 1, 32'h0, 1, 32'h0000_00F0);
    for (int i = 0; i < 3; i++) begin
      check("stall_ready", {31'd0, input_ready_o}, 32'd0);
      idle(1);
    end
    output_ready_i = 1'b1;
    idle(2);

    // Back-to-back: four instructions, one per cycle, drained in order.
    start = n_out;
    send(32'h0, 32'd10, 32'd1, 3'b000, 0, 0, 0, 3'b000, 20'h0, 1, 32'd11, 0, 32'h0);
    send(32'h0, 32'd20, 32'd2, 3'b000, 0, 0, 0, 3'b000, 20'h0, 1, 32'd22, 0, 32'h0);
    send(32'h0, 32'd30, 32'd3, 3'b000, 1, 0, 0, 3'b000, 20'h0, 1, 32'd27, 0, 32'h0);
    send(32'h0, 32'd40, 32'd4, 3'b000, 0, 0, 0, 3'b000, 20'h0, 1, 32'd44, 0, 32'h0);
    @(negedge clk); #1;
    check("b2b_count", n_out - start, 32'd4);
    idle(2);

    // Reset mid-stall discards the held instruction.
    output_ready_i = 1'b0;
    send(32'h1000, 32'h3, 32'h3, 3'b000, 0, 0, 0, 3'b001, 20'h00010, 1, 32'h6, 1, 32'h0000_1020);
    #2;
    rst_i = 1'b0;
    #1;
    check_all_zero("midreset");
    sb.delete();
    idle(1);
    @(negedge clk);
    rst_i = 1'b1;
    output_ready_i = 1'b1;
    #1;
    check("postreset_ready", {31'd0, input_ready_o}, 32'd1);
    check("postreset_valid", {31'd0, output_valid_o}, 32'd0);
    send(32'h0, 32'h2, 32'h3, 3'b000, 0, 0, 0, 3'b000, 20'h0, 1, 32'h5, 0, 32'h0);

    // Bounded drain of anything still in flight.
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    check("drain_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
